// File: rtl/uart_receive.sv
// UART receiver: start bit, WIDTH data bits LSB first, stop bit; each bit is sampled mid-bit.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int WIDTH            = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rx_wire_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             framing_error_out,
  output logic             parity_error_out,
  output logic             busy_out
);

  localparam int P    = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = P / 2;
  localparam int CW   = (P > 1) ? $clog2(P) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] data_reg;
  logic             sync_q;
  logic             rx_s;
  logic             rx_s_d;

  // The line idles high, so the synchroniser resets to 1 to avoid a fake start edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage see the previous stage's old value,
      // which is what turns three statements into a real three-flop chain.
      sync_q <= rx_wire_in;
      rx_s   <= sync_q;
      rx_s_d <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_flag;
`else
  assign parity_error_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      count             <= '0;
      index             <= '0;
      data_reg          <= '0;
      data_out          <= '0;
      valid_out         <= 1'b0;
      framing_error_out <= 1'b0;
      busy_out          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_out  <= 1'b0;
      par_flag          <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle; only the branch that reports sets them.
      valid_out         <= 1'b0;
      framing_error_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_out  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Edge-triggered start so a held-low (break) line cannot retrigger.
          if (rx_s_d && !rx_s) begin
            count    <= '0;
            index    <= '0;
            busy_out <= 1'b1;
            state    <= START;
`ifdef UART_RX_PARITY_EN
            par_flag <= 1'b0;
`endif
          end
        end

        START: begin
          if (count == CNT_HALF) begin
            if (!rx_s) begin
              count <= '0;
              state <= DATA;
            end else begin
              busy_out <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        DATA: begin
          if (count == CNT_LAST) begin
            data_reg[index] <= rx_s;
            count           <= '0;
            if (index == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (count == CNT_LAST) begin
            par_flag <= rx_s ^ (^data_reg);
            count    <= '0;
            state    <= STOP;
          end else begin
            count <= count + 1'b1;
          end
        end
`endif

        STOP: begin
          // Leave at mid-stop-bit so a start edge right after the stop bit is caught.
          if (count == CNT_LAST) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            if (!rx_s) begin
              framing_error_out <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_flag) begin
              parity_error_out <= 1'b1;
            end
`endif
            else begin
              data_out  <= data_reg;
              valid_out <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
